// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-controller command-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Arbiter FSM: one command in flight at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WR_REC  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection. Searches upward
// from ptr, wrapping modulo N, and returns the first requesting index both
// as a one-hot vector and as a binary index.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order starting at ptr; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares the memory controller's single host command port
// between NUM_REQ requesters with round-robin grants, one command at a time.
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables the read-data timeout
// (rsp_err can assert); without it RD_WAIT waits indefinitely and rsp_err
// stays 0.
//
// Handshake: a requester raises req_valid with stable rnw/addr/wdata and
// holds it until it sees its req_ready bit; the request is taken from the
// cycle the arbiter sampled it in IDLE, and req_ready pulses (together with
// the command strobe) the cycle after. Dropping req_valid before that sample
// simply means no grant. Completion is a single-cycle rsp_valid pulse to the
// granted requester, with rsp_rdata/rsp_err valid in the same cycle.
//
// Every output is a register loaded with the value that belongs to the state
// being entered, so output changes line up with state changes.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WR_WAIT    = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rnw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        cmd_n,
  output logic                        RDnWR,
  output logic [ADDR_W-1:0]           Addr_in,
  output logic                        Data_in_vld,
  output logic [DATA_W-1:0]           Data_in,
  input  logic [DATA_W-1:0]           Data_out,
  input  logic                        data_out_vld,
  output arb_state_t                  dbg_state
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (RD_TIMEOUT > WR_WAIT) ? RD_TIMEOUT : WR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic               rnw_q, rnw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_d, data_in_d;
  logic [ADDR_W-1:0]  addr_in_d;
  logic               rsp_err_d, busy_d, cmd_n_d, rdnwr_d, data_in_vld_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  assign dbg_state = state_q;

  // Next state, next pointer/latches and the output values of the next state.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    rnw_d         = rnw_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    cmd_n_d       = 1'b1;
    rdnwr_d       = 1'b0;
    addr_in_d     = '0;
    data_in_vld_d = 1'b0;
    data_in_d     = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = ISSUE;
          gidx_d      = pick_idx;
          rnw_d       = req_rnw[pick_idx];
          ptr_d       = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          req_ready_d = pick_grant;
          // Command fields are loaded straight from the winner so the strobe
          // appears in the ISSUE cycle itself.
          cmd_n_d     = 1'b0;
          rdnwr_d     = req_rnw[pick_idx];
          addr_in_d   = addr_arr[pick_idx];
          if (!req_rnw[pick_idx]) begin
            data_in_vld_d = 1'b1;
            data_in_d     = wdata_arr[pick_idx];
          end
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = rnw_q ? RD_WAIT : WR_REC;
      end

      WR_REC: begin
        if (cnt_q == CNT_W'(WR_WAIT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_WAIT: begin
        // Data arriving on the final timeout cycle still counts as good data.
        if (data_out_vld) begin
          state_d     = RESP;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;
          rsp_rdata_d = Data_out;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, arbitration bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      rnw_q       <= 1'b0;
      cnt_q       <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      cmd_n       <= 1'b1;
      RDnWR       <= 1'b0;
      Addr_in     <= '0;
      Data_in_vld <= 1'b0;
      Data_in     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      rnw_q       <= rnw_d;
      cnt_q       <= cnt_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      busy        <= busy_d;
      cmd_n       <= cmd_n_d;
      RDnWR       <= rdnwr_d;
      Addr_in     <= addr_in_d;
      Data_in_vld <= data_in_vld_d;
      Data_in     <= data_in_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NUM_REQ=4, WR_WAIT=4, RD_TIMEOUT=64).
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int WR_WAIT    = 4;
  localparam int RD_TIMEOUT = 64;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_rnw;
  logic [NUM_REQ*16-1:0]     req_addr;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic                      busy;
  logic                      cmd_n;
  logic                      RDnWR;
  logic [15:0]               Addr_in;
  logic                      Data_in_vld;
  logic [31:0]               Data_in;
  logic [31:0]               Data_out;
  logic                      data_out_vld;
  arb_state_t                dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WR_WAIT    (WR_WAIT),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rnw      (req_rnw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .cmd_n        (cmd_n),
    .RDnWR        (RDnWR),
    .Addr_in      (Addr_in),
    .Data_in_vld  (Data_in_vld),
    .Data_in      (Data_in),
    .Data_out     (Data_out),
    .data_out_vld (data_out_vld),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
    data_out_vld = 1'b0; Data_out = '0;
    tick(); tick();
    checks++;
    if (cmd_n !== 1'b1) begin failures++; $display("FAIL reset_cmd_n got=%b exp=1", cmd_n); end
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_err} !== 10'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {req_ready, rsp_valid, busy, rsp_err});
    end
    checks++;
    if ({RDnWR, Addr_in, Data_in_vld, Data_in, rsp_rdata} !== 82'b0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {RDnWR, Addr_in, Data_in_vld, Data_in, rsp_rdata});
    end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    rst = 1'b0;
    // A stray controller data pulse while idle must not create a response.
    data_out_vld = 1'b1; Data_out = 32'hFFFF_FFFF;
    tick();
    data_out_vld = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_stray_data got=%b/%b exp=0000/0", rsp_valid, busy);
    end
  endtask

  task automatic test_write_single();
    int quiet_bad;
    req_rnw[0] = 1'b0; req_addr[15:0] = 16'h1234; req_wdata[31:0] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    tick(); // T+1
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL wr_ready got=%b exp=0001", req_ready); end
    checks++;
    if (cmd_n !== 1'b0 || RDnWR !== 1'b0 || Data_in_vld !== 1'b1) begin
      failures++; $display("FAIL wr_strobe got=%b%b%b exp=001", cmd_n, RDnWR, Data_in_vld);
    end
    checks++;
    if (Addr_in !== 16'h1234 || Data_in !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_fields got=%h/%h exp=1234/deadbeef", Addr_in, Data_in);
    end
    req_valid = '0;
    tick(); // T+2
    checks++;
    if (cmd_n !== 1'b1 || Data_in_vld !== 1'b0) begin
      failures++; $display("FAIL wr_strobe_len got=%b%b exp=10", cmd_n, Data_in_vld);
    end
    quiet_bad = (rsp_valid !== 4'b0) ? 1 : 0;
    for (int k = 3; k <= 5; k++) begin
      tick();
      if (rsp_valid !== 4'b0) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad != 0) begin failures++; $display("FAIL wr_early_rsp got=1 exp=0"); end
    tick(); // T+6
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL wr_rsp got=%b/%h/%b exp=0001/00000000/0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick(); // T+7
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL wr_done got=%b/%b exp=0000/0", rsp_valid, busy);
    end
  endtask

  task automatic test_read_single();
    int quiet_bad;
    req_rnw[2] = 1'b1; req_addr[47:32] = 16'h0040;
    req_valid = 4'b0100;
    tick(); // T+1, strobe
    checks++;
    if (req_ready !== 4'b0100 || cmd_n !== 1'b0 || RDnWR !== 1'b1 || Data_in_vld !== 1'b0) begin
      failures++; $display("FAIL rd_strobe got=%b/%b%b%b exp=0100/010", req_ready, cmd_n, RDnWR, Data_in_vld);
    end
    checks++;
    if (Addr_in !== 16'h0040) begin failures++; $display("FAIL rd_addr got=%h exp=0040", Addr_in); end
    req_valid = '0;
    quiet_bad = 0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      if (rsp_valid !== 4'b0) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad != 0) begin failures++; $display("FAIL rd_early_rsp got=1 exp=0"); end
    data_out_vld = 1'b1; Data_out = 32'hA5A5A5A5; // strobe + 3
    tick();
    data_out_vld = 1'b0; Data_out = '0;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'hA5A5A5A5 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL rd_rsp got=%b/%h/%b exp=0100/a5a5a5a5/0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rd_done got=%b/%b exp=0000/0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    int nready, nrsp, first, second, bad_rsp;
    nready = 0; nrsp = 0; first = 0; second = 0; bad_rsp = 0;
    req_rnw[1] = 1'b0; req_addr[31:16] = 16'h0777; req_wdata[63:32] = 32'h1111_2222;
    req_valid = 4'b0010;
    for (int c = 0; c < 40 && nrsp < 2; c++) begin
      tick();
      if (req_ready !== 4'b0) begin
        if (nready == 0) first = c; else second = c;
        nready++;
        if (nready == 2) req_valid = '0;
      end
      if (rsp_valid !== 4'b0) begin
        nrsp++;
        if (rsp_valid !== 4'b0010) bad_rsp = 1;
      end
    end
    checks++;
    if (nready != 2 || nrsp != 2 || bad_rsp != 0) begin
      failures++; $display("FAIL b2b_count got=%0d/%0d/%0d exp=2/2/0", nready, nrsp, bad_rsp);
    end
    checks++;
    if (second - first != WR_WAIT + 3) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=%0d", second - first, WR_WAIT + 3);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] addr_tab [4];
    logic [31:0] exp_d;
    int exp_g, cur_g, ngrant, nrsp, delay;
    addr_tab[0] = 16'h0010; addr_tab[1] = 16'h0020; addr_tab[2] = 16'h0030; addr_tab[3] = 16'h0040;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_addr[16*i +: 16] = addr_tab[i];
    req_rnw = 4'hF;
    req_valid = 4'hF;
    exp_q = {};
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    cur_g = 0; ngrant = 0; nrsp = 0; delay = 0;
    for (int c = 0; c < 200 && nrsp < 5; c++) begin
      tick();
      data_out_vld = 1'b0;
      if (delay == 1) begin
        data_out_vld = 1'b1;
        Data_out = {16'hC0DE, addr_tab[cur_g]};
      end
      if (delay > 0) delay--;
      if (req_ready !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rr_extra_grant got=%b exp=none", req_ready);
        end else begin
          exp_g = int'(exp_q.pop_front());
          if (req_ready !== (4'b0001 << exp_g) || Addr_in !== addr_tab[exp_g]) begin
            failures++; $display("FAIL rr_grant got=%b/%h exp=%b/%h", req_ready, Addr_in, 4'b0001 << exp_g, addr_tab[exp_g]);
          end
          cur_g = exp_g;
        end
        ngrant++;
        if (ngrant == 5) req_valid = '0;
      end
      if (cmd_n === 1'b0) delay = 2;
      if (rsp_valid !== 4'b0) begin
        checks++;
        exp_d = {16'hC0DE, addr_tab[cur_g]};
        if (rsp_valid !== (4'b0001 << cur_g) || rsp_rdata !== exp_d || rsp_err !== 1'b0) begin
          failures++; $display("FAIL rr_rsp got=%b/%h/%b exp=%b/%h/0", rsp_valid, rsp_rdata, rsp_err, 4'b0001 << cur_g, exp_d);
        end
        nrsp++;
      end
    end
    data_out_vld = 1'b0;
    checks++;
    if (nrsp != 5 || exp_q.size() != 0) begin
      failures++; $display("FAIL rr_count got=%0d/%0d exp=5/0", nrsp, exp_q.size());
    end
    tick();
  endtask

  task automatic test_timeout();
    int quiet_bad;
    req_rnw[1] = 1'b1; req_addr[31:16] = 16'h0100;
    req_valid = 4'b0010;
    tick(); // T+1
    checks++;
    if (req_ready !== 4'b0010 || cmd_n !== 1'b0) begin
      failures++; $display("FAIL to_strobe got=%b/%b exp=0010/0", req_ready, cmd_n);
    end
    req_valid = '0;
    quiet_bad = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 0; k < RD_TIMEOUT; k++) begin // T+2 .. T+65
      tick();
      if (rsp_valid !== 4'b0) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad != 0) begin failures++; $display("FAIL to_early_rsp got=1 exp=0"); end
    tick(); // T+66
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL to_err_rsp got=%b/%b/%h exp=0010/1/00000000", rsp_valid, rsp_err, rsp_rdata);
    end
`else
    for (int k = 0; k < RD_TIMEOUT + 16; k++) begin
      tick();
      if (rsp_valid !== 4'b0 || busy !== 1'b1) quiet_bad = 1;
    end
    checks++;
    if (quiet_bad != 0) begin failures++; $display("FAIL to_wait_forever got=1 exp=0"); end
    data_out_vld = 1'b1; Data_out = 32'h0BAD_F00D;
    tick();
    data_out_vld = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL to_late_rsp got=%b/%b/%h exp=0010/0/0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
`endif
    tick(); // IDLE
    // Data on the last RD_WAIT cycle: good completion in every build.
    req_valid = 4'b0010;
    tick(); // T+1
    req_valid = '0;
    quiet_bad = 0;
    for (int k = 0; k < RD_TIMEOUT; k++) begin // up to T+65
      tick();
      if (rsp_valid !== 4'b0) quiet_bad = 1;
    end
    data_out_vld = 1'b1; Data_out = 32'h1357_9BDF;
    tick(); // T+66
    data_out_vld = 1'b0;
    checks++;
    if (quiet_bad != 0 || rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1357_9BDF) begin
      failures++; $display("FAIL to_last_cycle got=%0d/%b/%b/%h exp=0/0010/0/13579bdf", quiet_bad, rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_rnw[1] = 1'b1; req_addr[31:16] = 16'h0200;
    req_valid = 4'b0010;
    tick(); // T+1
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rm_ready got=%b exp=0010", req_ready); end
    req_valid = '0;
    tick(); tick(); // T+3
    checks++;
    if (dbg_state !== RD_WAIT || busy !== 1'b1) begin
      failures++; $display("FAIL rm_in_rdwait got=%0d/%b exp=%0d/1", dbg_state, busy, RD_WAIT);
    end
    rst = 1'b1;
    tick(); // T+4
    checks++;
    if (cmd_n !== 1'b1 || busy !== 1'b0 || rsp_valid !== 4'b0 || req_ready !== 4'b0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL rm_reset got=%b/%b/%b/%b/%0d exp=1/0/0000/0000/0", cmd_n, busy, rsp_valid, req_ready, dbg_state);
    end
    rst = 1'b0;
    data_out_vld = 1'b1; Data_out = 32'hDEAD_0001;
    tick(); // T+5
    data_out_vld = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_late_data got=%b/%b exp=0000/0", rsp_valid, busy);
    end
    req_rnw = 4'hF;
    req_addr[15:0] = 16'h0A00; req_addr[47:32] = 16'h0A02; req_addr[63:48] = 16'h0A03;
    req_valid = 4'b1101;
    tick(); // T+6
    checks++;
    if (req_ready !== 4'b0001 || Addr_in !== 16'h0A00) begin
      failures++; $display("FAIL rm_ptr_reset got=%b/%h exp=0001/0a00", req_ready, Addr_in);
    end
    req_valid = '0;
    tick(); // first RD_WAIT cycle
    data_out_vld = 1'b1; Data_out = 32'h600D_600D;
    tick();
    data_out_vld = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h600D_600D || rsp_err !== 1'b0) begin
      failures++; $display("FAIL rm_after_rsp got=%b/%h/%b exp=0001/600d600d/0", rsp_valid, rsp_rdata, rsp_err);
    end
    tick();
  endtask

  // Sequencer and final report.
  initial begin
    rst = 1'b1;
    req_valid = '0; req_rnw = '0; req_addr = '0; req_wdata = '0;
    data_out_vld = 1'b0; Data_out = '0;
    test_reset();
    test_write_single();
    test_read_single();
    test_back_to_back();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
